// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: tile sequencer and diagonal skew feeder for the systolic MAC array.
module sa_skew_feeder #(
    parameter int LEN = 4,
    parameter int DATA_W = 16,
    parameter int K_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LEN*DATA_W-1:0] a_data,
    input  logic [LEN*DATA_W-1:0] b_data,
    output logic                  sa_clear,
    output logic [LEN*DATA_W-1:0] sa_row_data,
    output logic [LEN-1:0]        sa_row_valid,
    output logic [LEN*DATA_W-1:0] sa_col_data,
    output logic [LEN-1:0]        sa_col_valid,
    input  logic                  sa_ready
);
    localparam int DC_W = $clog2(LEN + 1) + 1;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WAIT, S_DONE} state_t;
    state_t state, state_nx;
    logic [K_W-1:0] kreg, bcnt;
    logic [DC_W-1:0] dcnt;
    logic hs, last_beat;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign in_ready = state == S_FEED;
    assign sa_clear = state == S_CLEAR;
    assign hs = in_valid & in_ready;
    assign last_beat = hs && (bcnt + K_W'(1) == kreg);
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_CLEAR : S_IDLE;
            S_CLEAR: state_nx = (kreg != '0) ? S_FEED : S_DRAIN;
            S_FEED:  state_nx = last_beat ? S_DRAIN : S_FEED;
            S_DRAIN: state_nx = (dcnt == DC_W'(LEN)) ? S_WAIT : S_DRAIN;
            S_WAIT:  state_nx = sa_ready ? S_DONE : S_WAIT;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    // DRAIN lasts LEN+1 cycles so the deepest lane empties before ready is trusted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            kreg  <= '0;
            bcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) kreg <= k_len;
            bcnt <= (state == S_CLEAR) ? '0 : bcnt + K_W'(hs);
            dcnt <= (state == S_DRAIN) ? dcnt + DC_W'(1) : '0;
        end
    end
    for (genvar i = 0; i < LEN; i++) begin : g_lane
        logic [i:0]        v_sr;
        logic [DATA_W-1:0] a_sr [i+1];
        logic [DATA_W-1:0] b_sr [i+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_sr <= '0;
                for (int j = 0; j <= i; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else begin
                v_sr[0] <= hs;
                a_sr[0] <= hs ? a_data[i*DATA_W +: DATA_W] : '0;
                b_sr[0] <= hs ? b_data[i*DATA_W +: DATA_W] : '0;
                for (int j = 1; j <= i; j++) begin
                    v_sr[j] <= v_sr[j-1];
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end
        assign sa_row_valid[i] = v_sr[i];
        assign sa_col_valid[i] = v_sr[i];
        assign sa_row_data[i*DATA_W +: DATA_W] = a_sr[i];
        assign sa_col_data[i*DATA_W +: DATA_W] = b_sr[i];
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed checks of tile sequencing and lane skew.
module tb_sa_skew_feeder;
    localparam int LEN = 4;
    localparam int DW = 16;
    localparam int KW = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic sa_ready = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [LEN*DW-1:0] a_data = '0;
    logic [LEN*DW-1:0] b_data = '0;
    logic busy, done, in_ready, sa_clear;
    logic [LEN*DW-1:0] sa_row_data, sa_col_data;
    logic [LEN-1:0] sa_row_valid, sa_col_valid;
    int checks = 0;
    int failures = 0;
    logic [LEN-1:0] o_rv [64];
    logic [LEN*DW-1:0] o_row [64];
    logic [LEN*DW-1:0] o_col [64];
    logic o_busy [64];
    logic o_done [64];
    int n_clr, clr_at, n_done, done_at, n_busy, n_inrdy;
    int vcnt [LEN];

    always #5 clk = ~clk;

    sa_skew_feeder #(.LEN(LEN), .DATA_W(DW), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .sa_clear(sa_clear), .sa_row_data(sa_row_data), .sa_row_valid(sa_row_valid),
        .sa_col_data(sa_col_data), .sa_col_valid(sa_col_valid), .sa_ready(sa_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cycle c: outputs sampled at negedge c, then inputs for posedge c driven
    task automatic run(input logic [KW-1:0] k, input logic [63:0] iv, input logic [63:0] st,
                       input int rdy_from, input int ncyc);
        n_clr = 0; clr_at = -1; n_done = 0; done_at = -1; n_busy = 0; n_inrdy = 0;
        for (int i = 0; i < LEN; i++) vcnt[i] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            o_rv[c] = sa_row_valid;
            o_row[c] = sa_row_data;
            o_col[c] = sa_col_data;
            o_busy[c] = busy;
            o_done[c] = done;
            if (sa_clear) begin n_clr++; clr_at = c; end
            if (done) begin n_done++; done_at = c; end
            n_busy += int'(busy);
            n_inrdy += int'(in_ready);
            check("row_col_valid", {60'd0, sa_col_valid}, {60'd0, sa_row_valid});
            for (int i = 0; i < LEN; i++) begin
                vcnt[i] += int'(sa_row_valid[i]);
                if (!sa_row_valid[i])
                    check("idle_lane_zero", {32'd0, sa_row_data[i*DW +: DW], sa_col_data[i*DW +: DW]}, 64'd0);
            end
            start = st[c];
            k_len = (c == 0) ? k : 8'd7;
            in_valid = iv[c];
            sa_ready = (c >= rdy_from);
            for (int i = 0; i < LEN; i++) begin
                a_data[i*DW +: DW] = DW'(i + 1 + 10 * c);
                b_data[i*DW +: DW] = DW'(256 + i + 1 + 10 * c);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        sa_ready = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_ctrl", {58'd0, busy, done, in_ready, sa_clear, sa_row_valid[0], sa_col_valid[0]}, 64'd0);
        check("rst_valid", {56'd0, sa_row_valid, sa_col_valid}, 64'd0);
        check("rst_row_data", sa_row_data, 64'd0);
        check("rst_col_data", sa_col_data, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // k=3, in_valid held high
        run(8'd3, '1, 64'h1, 0, 14);
        check("t2_clr_n", n_clr, 1);
        check("t2_clr_at", clr_at, 1);
        check("t2_l0_first", {o_rv[3][0], o_row[3][15:0]}, {1'b1, 16'd21});
        check("t2_rv5", o_rv[5], 4'b0111);
        check("t2_rv6", o_rv[6], 4'b1110);
        check("t2_l3_first", {o_rv[6][3], o_row[6][63:48]}, {1'b1, 16'd24});
        check("t2_l3_last", {o_rv[8][3], o_row[8][63:48]}, {1'b1, 16'd44});
        check("t2_l1_col", {o_rv[4][1], o_col[4][31:16]}, {1'b1, 16'd278});
        check("t2_rv9", o_rv[9], 4'b0000);
        for (int i = 0; i < LEN; i++) check("t2_vcnt", vcnt[i], 3);
        check("t2_done_n", n_done, 1);
        check("t2_done_at", done_at, 11);
        check("t2_idle_after", o_busy[12], 1'b0);

        // k=4, in_valid every other cycle
        run(8'd4, 64'h154, 64'h1, 0, 18);
        check("t3_rv3", o_rv[3], 4'b0001);
        check("t3_l0_b0", o_row[3][15:0], 16'd21);
        check("t3_rv4", o_rv[4], 4'b0010);
        check("t3_l0_gap", o_row[4][15:0], 16'd0);
        check("t3_rv5", o_rv[5], 4'b0101);
        check("t3_rv6", o_rv[6], 4'b1010);
        check("t3_rv12", o_rv[12], 4'b1000);
        check("t3_l3_b3", o_row[12][63:48], 16'd84);
        for (int i = 0; i < LEN; i++) check("t3_vcnt", vcnt[i], 4);
        check("t3_done_at", done_at, 15);
        check("t3_done_n", n_done, 1);

        // k=0
        run(8'd0, '1, 64'h1, 0, 12);
        check("t4_clr_n", n_clr, 1);
        check("t4_inrdy_n", n_inrdy, 0);
        for (int i = 0; i < LEN; i++) check("t4_vcnt", vcnt[i], 0);
        check("t4_done_at", done_at, 8);
        check("t4_done_n", n_done, 1);

        // sa_ready held low through 20 WAIT cycles
        run(8'd1, '1, 64'h1, 28, 32);
        for (int c = 8; c <= 28; c++) check("t5_wait", {o_busy[c], o_done[c]}, 2'b10);
        check("t5_done_at", done_at, 29);
        check("t5_done_n", n_done, 1);
        check("t5_inrdy_n", n_inrdy, 1);
        for (int i = 0; i < LEN; i++) check("t5_vcnt", vcnt[i], 1);

        // start and in_valid poked outside their accepting states
        run(8'd2, 64'h228F, 64'h2409, 12, 18);
        for (int i = 0; i < LEN; i++) check("t6_vcnt", vcnt[i], 2);
        check("t6_clr_n", n_clr, 1);
        check("t6_done_n", n_done, 1);
        check("t6_done_at", done_at, 13);
        check("t6_busy_n", n_busy, 13);
        check("t6_inrdy_n", n_inrdy, 2);
        check("t6_idle", {o_busy[14], o_busy[17]}, 2'b00);

        // reset mid-FEED after two beats, then a clean tile
        run(8'd5, '1, 64'h1, 0, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t7_rst_ctrl", {busy, in_ready, done, sa_clear}, 4'b0000);
        check("t7_rst_valid", {sa_row_valid, sa_col_valid}, 8'h00);
        check("t7_rst_data", sa_row_data | sa_col_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_post_idle", {busy, done, sa_row_valid}, 6'd0);
        run(8'd3, '1, 64'h1, 0, 14);
        for (int i = 0; i < LEN; i++) check("t7_vcnt", vcnt[i], 3);
        check("t7_l0_first", {o_rv[3][0], o_row[3][15:0]}, {1'b1, 16'd21});
        check("t7_done_at", done_at, 11);
        check("t7_done_n", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Upstream feeder for the systolic MAC array.
- Accepts one K-step operand beat per handshake: LEN elements of A (row operands) plus LEN elements of B (column operands).
- Applies diagonal skew so lane i reaches the array i cycles after lane 0, and drives the array's row/column edge inputs with per-lane valid bits.
- Sequences each tile: pulses clear, feeds K beats, flushes the skew, waits for the array's ready, then signals done.

Parameters:
- LEN, 4, systolic array edge length (lanes per operand vector); must match the array's SYS_ARRAY_LEN.
- DATA_W, 16, element width in bits (BFloat16).
- K_W, 8, width of k_len; maximum K = 2^K_W - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  K_W  number of operand beats for the tile; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile result is stable in the array.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  feeder can take a beat; high only in FEED.
- a_data  in  LEN*DATA_W  A elements; lane i at bits [i*DATA_W +: DATA_W].
- b_data  in  LEN*DATA_W  B elements; same lane packing.
- sa_clear  out  1  clear pulse to the array accumulators.
- sa_row_data  out  LEN*DATA_W  skewed A lanes to array row inputs.
- sa_row_valid  out  LEN  per-lane valid for row inputs.
- sa_col_data  out  LEN*DATA_W  skewed B lanes to array column inputs.
- sa_col_valid  out  LEN  per-lane valid for column inputs.
- sa_ready  in  1  array ready (all array shift registers invalid; registered by the array).

Behaviour:
- Reset, asynchronous, active-high. All outputs and skew registers go to 0: busy=0, done=0, in_ready=0, sa_clear=0, all sa_*_valid=0, all sa_*_data=0. State goes to IDLE.
- Reset mid-tile discards all in-flight beats; no done is produced.

State machine:
- IDLE: start=1 latches k_len into kreg, goes to CLEAR. Start is ignored in all other states.
- CLEAR (1 cycle): sa_clear=1. Next state is FEED if kreg!=0, else DRAIN.
- FEED: in_ready=1.
  - A handshake is in_valid & in_ready. Each handshake increments beat counter bcnt.
  - The handshake on which bcnt reaches kreg moves the FSM to DRAIN.
  - In a cycle with no handshake, a bubble is inserted: valid=0, data=0 for that beat.
- DRAIN: counts LEN+1 cycles with no new beats; stage-0 inputs are invalid. This flushes the skew, and the array's registered ready then reflects real data. Then goes to WAIT.
- WAIT: stays until sa_ready=1, then goes to DONE.
- DONE (1 cycle): done=1, then IDLE.

Skew pipeline:
- Lane i has a shift chain of i+1 registers, for both A and B, carrying {valid, data}.
- A beat accepted at cycle t appears on lane i outputs at cycle t+1+i.
- Lane 0 latency is 1 cycle; lane LEN-1 latency is LEN cycles.
- sa_row_* and sa_col_* for the same lane always carry the same beat in the same cycle.
- Data is passed through unmodified; there is no arithmetic. Invalid beats always drive data=0.
- Consecutive handshakes produce back-to-back valid outputs per lane, with no gaps.

Boundary conditions:
- k_len=0: IDLE → CLEAR → DRAIN → WAIT → DONE. The array is cleared, no valid is driven, done still pulses.
- in_valid held high: one beat is accepted per cycle, so K beats take exactly K FEED cycles.
- in_valid asserted in states other than FEED: ignored, in_ready=0.
- start and done in the same cycle: start is ignored, because the FSM is not in IDLE.

Test Plan:
- Reset mid-FEED after 2 beats → next cycle all sa_*_valid=0, busy=0, in_ready=0; a subsequent start runs a full tile normally.
- LEN=4, k_len=3, in_valid always 1, a_data lanes {1,2,3,4}+10*beat → sa_clear high 1 cycle; beat0 lane0 at cycle+1 and lane3 at cycle+4; exactly 3 valid cycles per lane; done pulses once after sa_ready rises.
- k_len=4 with in_valid low every other cycle → 4 accepted beats; each lane shows invalid zero-data gaps at the same beat positions, skewed by lane index.
- k_len=0 → one sa_clear pulse, no valid on any lane, done after DRAIN plus sa_ready.
- sa_ready held low 20 cycles after DRAIN → FSM stays in WAIT, busy=1, done=0; sa_ready=1 → done the next cycle.
- start pulsed while busy and in_valid pulsed outside FEED → no k_len re-latch, no extra beats accepted, total valid count per lane = kreg.
